// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter sequencing fixed-timing accesses to an external 16-bit SRAM
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_wdata,
    output logic [15:0]       a_rdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [15:0]       b_wdata,
    output logic [15:0]       b_rdata,
    output logic              b_done,
    output logic [ADDR_W-1:0] ADDR,
    output logic [15:0]       Data_write,
    input  logic [15:0]       Data_read,
    output logic              tristate_oe,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_l;
    logic              last_owner;

    logic              grant_any;
    logic              grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;

    // On a tie the port that did not win last time gets the SRAM.
    assign grant_any = a_req | b_req;
    assign grant_b   = b_req & (~a_req | ~last_owner);
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            we_l        <= 1'b0;
            last_owner  <= 1'b1;
            owner       <= 1'b0;
            a_rdata     <= 16'h0000;
            b_rdata     <= 16'h0000;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            ADDR        <= '0;
            Data_write  <= 16'h0000;
            tristate_oe <= 1'b0;
            CE          <= 1'b1;
            UB          <= 1'b1;
            LB          <= 1'b1;
            OE          <= 1'b1;
            WE          <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        // ADDR and Data_write double as the latched request fields.
                        owner       <= grant_b;
                        we_l        <= sel_we;
                        ADDR        <= sel_addr;
                        CE          <= 1'b0;
                        UB          <= 1'b0;
                        LB          <= 1'b0;
                        OE          <= sel_we;
                        tristate_oe <= sel_we;
                        if (sel_we) begin
                            Data_write <= sel_wdata;
                        end
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= 4'(WAIT_CYCLES - 1);
                    WE    <= ~we_l;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        CE <= 1'b1;
                        UB <= 1'b1;
                        LB <= 1'b1;
                        OE <= 1'b1;
                        WE <= 1'b1;
                        if (!we_l) begin
                            if (owner) begin
                                b_rdata <= Data_read;
                            end else begin
                                a_rdata <= Data_read;
                            end
                        end
                        a_done     <= ~owner;
                        b_done     <= owner;
                        last_owner <= owner;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Bus drive was held one extra cycle past WE rising for data hold.
                    a_done      <= 1'b0;
                    b_done      <= 1'b0;
                    tristate_oe <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM model and transaction-level reference
module tb_sram_arbiter;

    localparam int W  = 2;
    localparam int AW = 20;

    logic          Clk = 1'b0;
    logic          RESET;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [15:0]   a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_done, b_done;
    logic [AW-1:0] ADDR;
    logic [15:0]   Data_write;
    logic [15:0]   Data_read;
    logic          tristate_oe, CE, UB, LB, OE, WE, owner;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .Clk(Clk), .RESET(RESET),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done),
        .ADDR(ADDR), .Data_write(Data_write), .Data_read(Data_read),
        .tristate_oe(tristate_oe), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .owner(owner)
    );

    // Latency-only instances with WAIT_CYCLES of 1 and 15.
    logic [1:0]       l_req;
    logic [1:0]       l_done;
    logic [1:0][15:0] l_rdata;

    for (genvar g = 0; g < 2; g++) begin : g_lat
        logic [15:0]   brd, dw;
        logic [AW-1:0] ad;
        logic          bd, toe, ce, ub, lb, oe, we, own;
        sram_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 15), .ADDR_W(AW)) u_lat (
            .Clk(Clk), .RESET(RESET),
            .a_req(l_req[g]), .a_we(1'b0), .a_addr(20'h00001), .a_wdata(16'h0000),
            .a_rdata(l_rdata[g]), .a_done(l_done[g]),
            .b_req(1'b0), .b_we(1'b0), .b_addr(20'h00000), .b_wdata(16'h0000),
            .b_rdata(brd), .b_done(bd),
            .ADDR(ad), .Data_write(dw), .Data_read(16'hA5A5),
            .tristate_oe(toe), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
            .owner(own)
        );
    end

    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] exp_a_rd, exp_b_rd;
    logic        last_win;

    logic [15:0] sram    [logic [AW-1:0]];
    logic [15:0] ref_mem [logic [AW-1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // External SRAM: reacts to the strobes, not to the arbiter's internals.
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (!CE && !WE && tristate_oe) sram[ADDR] = Data_write;
        if (!CE && !OE) Data_read = sram.exists(ADDR) ? sram[ADDR] : 16'h0000;
        else            Data_read = 16'hDEAD;
        if (RESET) begin
            if (!WE) begin
                check("we_vs_oe", OE, 1);
                check("we_vs_ce", CE, 0);
            end
            check("one_done", a_done & b_done, 0);
        end
    end

    task automatic set_port(input logic port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [15:0] wdata);
        if (port) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // One transfer from an IDLE cycle, checking the strobe timeline cycle by cycle.
    task automatic do_xfer(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rd, input logic chg);
        set_port(port, 1'b1, we, addr, wdata);
        for (int k = 1; k <= 2 + W; k++) begin
            @(negedge Clk);
            if (k <= 1 + W) begin
                check("x_ce", CE, 0);
                check("x_ublb", {UB, LB}, 0);
                check("x_addr", ADDR, addr);
                check("x_oe", OE, we);
                check("x_we", WE, !(we && k >= 2));
                check("x_toe", tristate_oe, we);
                check("x_done_early", {a_done, b_done}, 0);
                check("x_owner", owner, port);
                if (we) check("x_dw", Data_write, wdata);
            end else begin
                check("x_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
                check("x_toe_hold", tristate_oe, we);
                check("x_addr_hold", ADDR, addr);
                check("x_a_done", a_done, !port);
                check("x_b_done", b_done, port);
                if (!we) begin
                    if (port) exp_b_rd = exp_rd;
                    else      exp_a_rd = exp_rd;
                end
                check("x_a_rdata", a_rdata, exp_a_rd);
                check("x_b_rdata", b_rdata, exp_b_rd);
                set_port(port, 1'b0, we, addr, wdata);
            end
            if (chg && k == 2) begin
                if (port) b_addr = 20'h00020;
                else      a_addr = 20'h00020;
            end
        end
        @(negedge Clk);
        check("x_idle_toe", tristate_oe, 0);
        check("x_idle_done", {a_done, b_done}, 0);
        last_win = port;
    endtask

    // Random phase reference: transaction-level queueing with round-robin choice.
    logic        pend    [2];
    logic        p_we    [2];
    logic [AW-1:0] p_addr [2];
    logic [15:0] p_wdata [2];

    task automatic random_phase(input int n_cycles);
        logic          busy = 1'b0;
        logic          win, last, t_we;
        logic [AW-1:0] t_addr;
        logic [15:0]   t_wdata, rd;
        int            exp_done = 0, free_at, g_cyc = 0;
        last    = last_win;
        free_at = cyc + 1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int n = 0; n < n_cycles; n++) begin
            @(negedge Clk);
            if (busy && cyc == exp_done) begin
                check("rnd_a_done", a_done, !win);
                check("rnd_b_done", b_done, win);
                check("rnd_owner", owner, win);
                if (t_we) begin
                    ref_mem[t_addr] = t_wdata;
                end else begin
                    rd = ref_mem.exists(t_addr) ? ref_mem[t_addr] : 16'h0000;
                    if (win) exp_b_rd = rd;
                    else     exp_a_rd = rd;
                end
                busy      = 1'b0;
                pend[win] = 1'b0;
                set_port(win, 1'b0, p_we[win], p_addr[win], p_wdata[win]);
            end else begin
                check("rnd_no_done", {a_done, b_done}, 0);
            end
            check("rnd_a_rdata", a_rdata, exp_a_rd);
            check("rnd_b_rdata", b_rdata, exp_b_rd);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]    = 1'b1;
                    p_we[p]    = 1'($urandom_range(0, 1));
                    p_addr[p]  = 20'h00040 + 20'($urandom_range(0, 7));
                    p_wdata[p] = 16'($urandom);
                    set_port(1'(p), 1'b1, p_we[p], p_addr[p], p_wdata[p]);
                end
            end
            // The granted requester may scribble on its inputs; the latched copy must win.
            if (busy && cyc > g_cyc && $urandom_range(0, 3) == 0) begin
                p_we[win]    = 1'($urandom_range(0, 1));
                p_addr[win]  = 20'h00040 + 20'($urandom_range(0, 7));
                p_wdata[win] = 16'($urandom);
                set_port(win, 1'b1, p_we[win], p_addr[win], p_wdata[win]);
            end
            if (!busy && cyc >= free_at && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) win = !last;
                else                    win = pend[1];
                last     = win;
                t_we     = p_we[win];
                t_addr   = p_addr[win];
                t_wdata  = p_wdata[win];
                g_cyc    = cyc;
                exp_done = cyc + 2 + W;
                free_at  = cyc + 3 + W;
                busy     = 1'b1;
            end
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        repeat (4 + W) @(negedge Clk);
        check("rnd_drained", {a_done, b_done, CE}, 3'b001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, d_a, d_b;
        int lat [2];
        RESET = 1'b0;
        l_req = 2'b00;
        set_port(1'b0, 1'b0, 1'b0, '0, 16'h0);
        set_port(1'b1, 1'b0, 1'b0, '0, 16'h0);
        sram[20'h00010] = 16'h1234;
        sram[20'h00020] = 16'h5555;
        sram[20'h0FFFF] = 16'h7777;
        exp_a_rd = 16'h0000;
        exp_b_rd = 16'h0000;
        last_win = 1'b1;
        repeat (3) @(negedge Clk);

        check("rst_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        check("rst_toe", tristate_oe, 0);
        check("rst_done", {a_done, b_done}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_addr", ADDR, 0);
        check("rst_dw", Data_write, 0);
        check("rst_owner", owner, 0);
        RESET = 1'b1;

        // Simultaneous requests held continuously: A first, then strict alternation.
        set_port(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0);
        set_port(1'b1, 1'b1, 1'b0, 20'h0FFFF, 16'h0);
        p = 3 + W;
        for (int k = 1; k <= 4 * p - 1; k++) begin
            @(negedge Clk);
            d_a = 0;
            d_b = 0;
            if (k >= 2 + W && (k - (2 + W)) % p == 0) begin
                if (((k - (2 + W)) / p) % 2 == 0) d_a = 1;
                else                              d_b = 1;
            end
            check("rr_a_done", a_done, d_a);
            check("rr_b_done", b_done, d_b);
            if (d_a == 1) begin
                check("rr_owner_a", owner, 0);
                check("rr_a_rdata", a_rdata, 16'h1234);
            end
            if (d_b == 1) begin
                check("rr_owner_b", owner, 1);
                check("rr_b_rdata", b_rdata, 16'h7777);
            end
        end
        a_req    = 1'b0;
        b_req    = 1'b0;
        exp_a_rd = 16'h1234;
        exp_b_rd = 16'h7777;
        @(negedge Clk);

        do_xfer(1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0);
        do_xfer(1'b1, 1'b1, 20'h0FFFF, 16'hBEEF, 16'h0000, 1'b0);
        do_xfer(1'b1, 1'b0, 20'h0FFFF, 16'h0000, 16'hBEEF, 1'b0);
        exp_a_rd = 16'h0000;
        do_xfer(1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b1);

        // Asynchronous reset in the middle of a write.
        set_port(1'b1, 1'b1, 1'b1, 20'h00300, 16'hCAFE);
        repeat (2) @(negedge Clk);
        check("ab_we_low", WE, 0);
        #1 RESET = 1'b0;
        #1;
        check("ab_we", WE, 1);
        check("ab_ce", CE, 1);
        check("ab_toe", tristate_oe, 0);
        check("ab_done", {a_done, b_done}, 0);
        b_req    = 1'b0;
        exp_a_rd = 16'h0000;
        exp_b_rd = 16'h0000;
        repeat (3) begin
            @(negedge Clk);
            check("ab_hold_done", {a_done, b_done}, 0);
            check("ab_hold_strobes", {CE, WE, OE}, 3'b111);
        end
        RESET = 1'b1;
        do_xfer(1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0);

        // Latency of the extreme WAIT_CYCLES builds.
        lat[0] = 0;
        lat[1] = 0;
        l_req  = 2'b11;
        for (int k = 1; k <= 24; k++) begin
            @(negedge Clk);
            for (int i = 0; i < 2; i++) begin
                if (l_done[i] && l_req[i]) begin
                    lat[i]   = k;
                    l_req[i] = 1'b0;
                    check("lat_rdata", l_rdata[i], 16'hA5A5);
                end
            end
        end
        check("lat_w1", lat[0], 3);
        check("lat_w15", lat[1], 17);

        random_phase(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 1Mx16 SRAM between two requesters: the CPU memory port (MAR/MDR side, port A) and a program/debug loader port (port B).
- Latches the winning request and sequences one fixed-timing read or write, driving the active-low SRAM strobes and the tristate write enable.
- Returns read data with a one-cycle done pulse.
- Sits between the SLC-3 memory path / loader and the 16-bit tristate data buffer, replacing direct strobe generation by the state controller.

Parameters:
- WAIT_CYCLES, 2: number of ACCESS cycles per transfer (legal 1..15).
- ADDR_W, 20: SRAM address width.

Ports:
- Clk  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous active-low reset
- a_req  in  1  port A (CPU) request, level, held until a_done
- a_we  in  1  port A write(1)/read(0)
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  16  port A write data
- a_rdata  out  16  port A read data, valid while a_done=1
- a_done  out  1  port A completion pulse, one cycle
- b_req, b_we, b_addr, b_wdata, b_rdata, b_done: port B (loader) equivalents, same widths and meaning
- ADDR  out  ADDR_W  SRAM address
- Data_write  out  16  data to tristate buffer
- Data_read  in  16  data from tristate buffer
- tristate_oe  out  1  tristate drive enable (1 = drive bus)
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
- owner  out  1  0 = A holds or last held the SRAM, 1 = B

Behaviour:
- Reset (RESET=0, asynchronous):
  - State IDLE.
  - CE/UB/LB/OE/WE = 1.
  - tristate_oe = 0.
  - a_done = b_done = 0.
  - a_rdata, b_rdata, ADDR, Data_write = 0.
  - last_owner = B, so A wins the first tie; owner = 0.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If no request, stay.
  - If exactly one request, grant it.
  - If both requests, grant the port not equal to last_owner (round-robin).
  - On the grant edge, latch we, addr and wdata of the winner into internal registers and set owner. Requester changes after this edge are ignored.
  - Go to SETUP.
- SETUP (1 cycle):
  - ADDR = latched addr.
  - CE = UB = LB = 0.
  - Read: OE = 0. Write: OE = 1, tristate_oe = 1, Data_write = latched wdata.
  - WE stays 1.
- ACCESS (WAIT_CYCLES cycles, 4-bit counter loaded with WAIT_CYCLES-1 on entry, decrement to 0):
  - Strobes as in SETUP, except WE = 0 for writes.
  - Read: Data_read captured into the winner's rdata register on the final ACCESS edge.
- DONE (1 cycle):
  - CE/UB/LB/OE/WE = 1.
  - tristate_oe stays 1 for writes (hold time); ADDR holds.
  - Winner's done = 1; the other port's done = 0.
  - last_owner <= winner.
  - Next state IDLE.
- Latency: a request sampled in IDLE at cycle 0 gives SETUP at 1, ACCESS at 2..1+WAIT_CYCLES, done at 2+WAIT_CYCLES, IDLE at 3+WAIT_CYCLES.
- Back-to-back: a request still high in IDLE after done counts as a new transfer. Requesters must drop req in the cycle after done to avoid a repeat.
- A loser's request stays pending, is not latched, and is granted at the next IDLE.
- rdata of each port holds its last read value until that port's next read completes. Writes do not alter rdata.
- Only one of a_done/b_done is ever high. WE=0 never coincides with OE=0 or CE=1.
- Reset mid-transfer: immediate abort, strobes released, no done issued, SRAM contents for an aborted write are undefined.

Test Plan:
- Reset, then A read at addr 0x00010 (SRAM holds 0x1234), WAIT_CYCLES=2 -> CE/OE low for cycles 1–3, WE stays 1, a_done at cycle 4 with a_rdata=0x1234, b_done stays 0.
- B write 0xBEEF to 0x0FFFF -> tristate_oe high for cycles 1–4, WE low only in cycles 2–3, Data_write=0xBEEF, b_done at cycle 4. A following B read of 0x0FFFF returns 0xBEEF.
- a_req and b_req rise together from reset -> A served first (owner=0), then B immediately after (owner=1, b_done 5 cycles after a_done). Both held continuously -> grants alternate A,B,A,B.
- A read latched; a_addr changed to 0x00020 during ACCESS -> ADDR stays 0x00010 and the returned data is from 0x00010.
- RESET low during ACCESS of a write -> WE/CE return to 1 and tristate_oe to 0 in the same cycle with no clock edge, no done pulse; after release, state is IDLE and the next A request completes normally.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds -> done at cycle 3 and cycle 17 respectively.
